// File: rtl/f4_pkg.sv
// Shared F-4 definitions: core opcode/mask constants plus the program loader's
// frame sync byte, state encoding and frame byte-count helpers.
package f4_pkg;

    localparam logic [3:0]  F4_OP_NOP   = 4'h0;
    localparam logic [3:0]  F4_OP_LD    = 4'h1;
    localparam logic [3:0]  F4_OP_ST    = 4'h2;
    localparam logic [3:0]  F4_OP_JMP   = 4'h3;
    localparam logic [15:0] F4_PC_MASK  = 16'hFFFF;

    localparam logic [7:0]  LDR_SYNC    = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_HDR,
        LDR_DATA,
        LDR_WRITE,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERROR
    } ldr_state_e;

    // Address field is sent as whole bytes, so a partial top byte still costs a byte.
    function automatic int ldr_addr_bytes(input int aw);
        return (aw + 7) / 8;
    endfunction

    function automatic int ldr_word_bytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/f4_bus_mux.sv
// Selects who drives the genram port: the program loader while own_bus=1,
// otherwise the F-4 core.
module f4_bus_mux #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          own_bus,
    input  logic [AW-1:0] ldr_addr,
    input  logic          ldr_rw,
    input  logic [DW-1:0] ldr_wdata,
    input  logic [AW-1:0] core_addr,
    input  logic          core_rw,
    input  logic [DW-1:0] core_wdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata
);

    assign ram_addr  = own_bus ? ldr_addr  : core_addr;
    assign ram_rw    = own_bus ? ldr_rw    : core_rw;
    assign ram_wdata = own_bus ? ldr_wdata : core_wdata;

endmodule

// File: rtl/f4_prog_loader.sv
// F-4 program loader: parses SYNC/ADDR/LEN/DATA/CSUM frames from the host link,
// writes words into genram and holds the core in reset while loading.
//
// state | meaning
// IDLE  | waiting for SYNC, other bytes discarded
// HDR   | collecting address then length bytes
// DATA  | collecting bytes of the current word
// WRITE | one-cycle write strobe to genram
// CSUM  | waiting for the checksum byte
// DONE  | frame good, core released next cycle
// ERROR | frame bad, core stays in reset
module f4_prog_loader
    import f4_pkg::*;
#(
    parameter int         DW   = 16,
    parameter int         AW   = 16,
    parameter logic [7:0] SYNC = LDR_SYNC
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          own_bus,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_rstn,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] core_addr,
    input  logic          core_rw,
    input  logic [DW-1:0] core_wdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata
);

    localparam int         AB       = ldr_addr_bytes(AW);
    localparam int         WB       = ldr_word_bytes(DW);
    localparam logic [7:0] AB_C     = 8'(AB);
    localparam logic [7:0] HDR_LAST = 8'(AB + 1);
    localparam logic [7:0] WB_LAST  = 8'(WB - 1);

    ldr_state_e    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   left_q, left_d;
    logic [DW-1:0] word_q, word_d;
    logic [7:0]    sum_q, sum_d;
    logic          in_ready_q, in_ready_d;
    logic          own_bus_q, own_bus_d;
    logic          mem_rw_q, mem_rw_d;
    logic          cpu_rstn_q, cpu_rstn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          xfer;
    logic [7:0]    sum_nx;
    logic [AW+7:0] addr_sh;
    logic [DW+7:0] word_sh;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        left_d  = left_q;
        word_d  = word_q;
        sum_d   = sum_q;
        done_d  = done_q;
        err_d   = err_q;
        xfer    = in_valid & in_ready_q;
        sum_nx  = sum_q + in_data;
        addr_sh = {addr_q, in_data};
        word_sh = {word_q, in_data};

        case (state_q)
            LDR_IDLE: begin
                if (xfer && in_data == SYNC) begin
                    state_d = LDR_HDR;
                    cnt_d   = 8'd0;
                    sum_d   = 8'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LDR_HDR: begin
                if (xfer) begin
                    sum_d = sum_nx;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q < AB_C) addr_d = addr_sh[AW-1:0];
                    else              len_d  = {len_q[7:0], in_data};
                    if (cnt_q == HDR_LAST) begin
                        cnt_d   = 8'd0;
                        left_d  = len_d;
                        state_d = (len_d == 16'd0) ? LDR_CSUM : LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                if (xfer) begin
                    sum_d  = sum_nx;
                    word_d = word_sh[DW-1:0];
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == WB_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = LDR_WRITE;
                    end
                end
            end
            LDR_WRITE: begin
                addr_d  = addr_q + 1'b1;
                left_d  = left_q - 16'd1;
                state_d = (left_q == 16'd1) ? LDR_CSUM : LDR_DATA;
            end
            LDR_CSUM: begin
                if (xfer) begin
                    sum_d = sum_nx;
                    if (sum_nx == 8'd0) begin
                        state_d = LDR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LDR_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = LDR_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        in_ready_d = (state_d == LDR_IDLE) || (state_d == LDR_HDR) ||
                     (state_d == LDR_DATA) || (state_d == LDR_CSUM);
        own_bus_d  = (state_d == LDR_HDR)  || (state_d == LDR_DATA) ||
                     (state_d == LDR_WRITE) || (state_d == LDR_CSUM);
        busy_d     = own_bus_d;
        mem_rw_d   = (state_d != LDR_WRITE);
        // A failed frame keeps the core in reset until a later frame succeeds.
        cpu_rstn_d = (state_d == LDR_IDLE) && !err_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= LDR_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            left_q     <= '0;
            word_q     <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            own_bus_q  <= 1'b0;
            mem_rw_q   <= 1'b1;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            left_q     <= left_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            in_ready_q <= in_ready_d;
            own_bus_q  <= own_bus_d;
            mem_rw_q   <= mem_rw_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign own_bus   = own_bus_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign cpu_rstn  = cpu_rstn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    f4_bus_mux #(.DW(DW), .AW(AW)) u_bus_mux (
        .own_bus    (own_bus_q),
        .ldr_addr   (addr_q),
        .ldr_rw     (mem_rw_q),
        .ldr_wdata  (word_q),
        .core_addr  (core_addr),
        .core_rw    (core_rw),
        .core_wdata (core_wdata),
        .ram_addr   (ram_addr),
        .ram_rw     (ram_rw),
        .ram_wdata  (ram_wdata)
    );

endmodule

// File: tb/tb_f4_prog_loader.sv
// Directed bench for f4_prog_loader: frame loads, checksum error, address wrap,
// empty frame, host stalls with garbage, and mid-frame reset.
module tb_f4_prog_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, own_bus, mem_rw, cpu_rstn, busy, done, err;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] core_addr, core_wdata;
    logic        core_rw;
    logic [15:0] ram_addr, ram_wdata;
    logic        ram_rw;

    int errors = 0;
    int checks = 0;
    bit gap_en = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];

    always #5 clk = ~clk;

    f4_prog_loader dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .own_bus(own_bus), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn),
        .busy(busy), .done(done), .err(err),
        .core_addr(core_addr), .core_rw(core_rw), .core_wdata(core_wdata),
        .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_wdata(ram_wdata)
    );

    // Log every write genram would see through the mux.
    always @(negedge clk) begin
        if (rstn && ram_rw == 1'b0) begin
            wa.push_back(ram_addr);
            wd.push_back(ram_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit   ok;
        ok = 0;
        if (gap_en) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            if (r) ok = 1;
        end
        #1;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte timeout: byte %02h not accepted, required accept within 50 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] n,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [7:0] cs);
        send_byte(8'hA5);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        if (n >= 16'd1) begin send_byte(w0[15:8]); send_byte(w0[7:0]); end
        if (n >= 16'd2) begin send_byte(w1[15:8]); send_byte(w1[7:0]); end
        send_byte(cs);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        checks++;
        if ({in_ready, own_bus, mem_rw, cpu_rstn, busy, done, err} !== 7'b0010000 ||
            mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL %s: rdy/own/rw/crst/busy/done/err=%b addr=%h wdata=%h, required 0010000 0000 0000",
                     tag, {in_ready, own_bus, mem_rw, cpu_rstn, busy, done, err}, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        checks++;
        if (ram_addr !== 16'h5A5A || ram_wdata !== 16'hC3C3 || ram_rw !== 1'b1) begin
            errors++;
            $display("FAIL reset_mux_core: ram addr=%h wdata=%h rw=%b, required 5a5a c3c3 1",
                     ram_addr, ram_wdata, ram_rw);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || cpu_rstn !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b cpu_rstn=%b busy=%b, required 1 1 0",
                     in_ready, cpu_rstn, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        logic [7:0] hdr [4] = '{8'h00, 8'h10, 8'h00, 8'h02};
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || own_bus !== 1'b1 || cpu_rstn !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_sync: busy=%b own=%b cpu_rstn=%b done=%b, required 1 1 0 0",
                     busy, own_bus, cpu_rstn, done);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_byte(hdr[i]);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
        // Strobe must appear in the cycle right after the last data byte is taken.
        @(negedge clk);
        checks++;
        if (mem_rw !== 1'b0 || in_ready !== 1'b0 || mem_addr !== 16'h0011 || mem_wdata !== 16'hABCD) begin
            errors++;
            $display("FAIL basic_latency: rw=%b rdy=%b addr=%h wdata=%h, required 0 0 0011 abcd",
                     mem_rw, in_ready, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        send_byte(8'h30);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || own_bus !== 1'b0 || cpu_rstn !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_cycle: done=%b err=%b busy=%b own=%b cpu_rstn=%b, required 1 0 0 0 0",
                     done, err, busy, own_bus, cpu_rstn);
        end
        @(negedge clk);
        checks++;
        if (cpu_rstn !== 1'b1 || in_ready !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: cpu_rstn=%b in_ready=%b done=%b, required 1 1 1",
                     cpu_rstn, in_ready, done);
        end
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'h0010 || wd[0] !== 16'h1234 ||
            wa[1] !== 16'h0011 || wd[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL basic_writes: count=%0d first=%h:%h, required 2 writes 0010:1234 0011:abcd",
                     wa.size(), wa.size() > 0 ? wa[0] : 16'hxxxx, wd.size() > 0 ? wd[0] : 16'hxxxx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bad_csum();
        wa.delete(); wd.delete();
        send_frame(16'h0010, 16'd2, 16'h1234, 16'hABCD, 8'h31);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || own_bus !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum_flags: err=%b done=%b busy=%b own=%b, required 1 0 0 0",
                     err, done, busy, own_bus);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (cpu_rstn !== 1'b0 || in_ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL bad_csum_hold: cpu_rstn=%b in_ready=%b err=%b, required 0 1 1",
                     cpu_rstn, in_ready, err);
        end
        checks++;
        if (wa.size() != 2 || wa[1] !== 16'h0011 || wd[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL bad_csum_writes: count=%0d, required 2 writes kept", wa.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_garbage_stall();
        wa.delete(); wd.delete();
        gap_en = 1;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL garbage_idle: busy=%b err=%b, required 0 1", busy, err);
        end
        send_frame(16'h0010, 16'd2, 16'h1234, 16'hABCD, 8'h30);
        gap_en = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_rstn !== 1'b1) begin
            errors++;
            $display("FAIL garbage_result: done=%b err=%b cpu_rstn=%b, required 1 0 1",
                     done, err, cpu_rstn);
        end
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'h0010 || wd[0] !== 16'h1234 ||
            wa[1] !== 16'h0011 || wd[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL garbage_writes: count=%0d, required 2 writes 0010:1234 0011:abcd", wa.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_addr_wrap();
        wa.delete(); wd.delete();
        send_frame(16'hFFFF, 16'd2, 16'h1111, 16'h2222, 8'h9A);
        @(negedge clk);
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'hFFFF || wd[0] !== 16'h1111 ||
            wa[1] !== 16'h0000 || wd[1] !== 16'h2222 || done !== 1'b1) begin
            errors++;
            $display("FAIL addr_wrap: count=%0d second=%h:%h done=%b, required ffff:1111 0000:2222 done 1",
                     wa.size(), wa.size() > 1 ? wa[1] : 16'hxxxx, wd.size() > 1 ? wd[1] : 16'hxxxx, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_len_zero();
        wa.delete(); wd.delete();
        send_frame(16'h1234, 16'd0, 16'h0000, 16'h0000, 8'hBA);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wa.size() != 0 || done !== 1'b1 || err !== 1'b0 || cpu_rstn !== 1'b1) begin
            errors++;
            $display("FAIL len_zero: writes=%0d done=%b err=%b cpu_rstn=%b, required 0 1 0 1",
                     wa.size(), done, err, cpu_rstn);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midframe_reset();
        wa.delete(); wd.delete();
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h40);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77);
        rstn = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midframe_reset_values");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wa.size() != 1 || wa[0] !== 16'h0040 || wd[0] !== 16'h5566) begin
            errors++;
            $display("FAIL midframe_partial: writes=%0d, required exactly 1 (0040:5566)", wa.size());
        end
        wa.delete(); wd.delete();
        send_frame(16'h0010, 16'd2, 16'h1234, 16'hABCD, 8'h30);
        @(negedge clk);
        checks++;
        if (wa.size() != 2 || wa[0] !== 16'h0010 || wd[1] !== 16'hABCD || done !== 1'b1) begin
            errors++;
            $display("FAIL midframe_reload: writes=%0d done=%b, required 2 writes and done 1",
                     wa.size(), done);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rstn       = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        core_addr  = 16'h5A5A;
        core_rw    = 1'b1;
        core_wdata = 16'hC3C3;
        test_reset();
        test_basic_frame();
        test_bad_csum();
        test_garbage_stall();
        test_addr_wrap();
        test_len_zero();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
